// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I fields and immediates into instruction words on a valid/ready stream,
// expanding li rd, imm32 into one or two real instructions.
module inst_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  I_fmt,
    input  logic        pseudo_li,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm32,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic        err
);
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    typedef enum logic [1:0] {EMPTY, FULL, FULL_PEND} state_t;

    state_t      state, state_n;
    logic [31:0] pend;
    logic        fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
    logic        one_hot, is_shift, sext12, sext13, sext21, imm_ok, legal;
    logic [31:0] enc_w, lui_w, addi_w, word0, word1;
    logic [19:0] li_hi;
    logic [4:0]  addi_rs1;
    logic        two_word, accept, load, drain;

    always_comb begin
        {fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j} = I_fmt;
        one_hot  = (I_fmt != 6'd0) && ((I_fmt & (I_fmt - 6'd1)) == 6'd0);
        is_shift = fmt_i && (funct3[1:0] == 2'b01);
        sext12   = imm32 == {{20{imm32[11]}}, imm32[11:0]};
        sext13   = imm32 == {{19{imm32[12]}}, imm32[12:0]};
        sext21   = imm32 == {{11{imm32[20]}}, imm32[20:0]};
        imm_ok   = fmt_r             ? 1'b1 :
                   is_shift          ? (imm32[31:5] == 27'd0) :
                   (fmt_i || fmt_s)  ? sext12 :
                   fmt_b             ? (sext13 && !imm32[0]) :
                   fmt_j             ? (sext21 && !imm32[0]) :
                                       (imm32[11:0] == 12'd0);
        legal    = pseudo_li || (one_hot && imm_ok);
    end

    always_comb begin
        enc_w = fmt_r    ? {funct7, rs2, rs1, funct3, rd, opcode} :
                is_shift ? {funct7, imm32[4:0], rs1, funct3, rd, opcode} :
                fmt_i    ? {imm32[11:0], rs1, funct3, rd, opcode} :
                fmt_s    ? {imm32[11:5], rs2, rs1, funct3, imm32[4:0], opcode} :
                fmt_b    ? {imm32[12], imm32[10:5], rs2, rs1, funct3, imm32[4:1], imm32[11], opcode} :
                fmt_u    ? {imm32[31:12], rd, opcode} :
                           {imm32[20], imm32[10:1], imm32[11], imm32[19:12], rd, opcode};
    end

    // Rounding the upper part by bit 11 compensates for ADDI sign-extending its low 12 bits.
    always_comb begin
        li_hi    = imm32[31:12] + {19'd0, imm32[11]};
        addi_rs1 = sext12 ? 5'd0 : rd;
        lui_w    = {li_hi, rd, OP_LUI};
        addi_w   = {imm32[11:0], addi_rs1, 3'b000, rd, OP_ADDI};
        two_word = pseudo_li && !sext12 && (imm32[11:0] != 12'd0);
        word0    = !pseudo_li ? enc_w : sext12 ? addi_w : lui_w;
        word1    = addi_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_n;
    end

    always_comb begin
        accept  = in_valid && in_ready;
        load    = accept && legal;
        drain   = out_valid && out_ready;
        state_n = (state == FULL_PEND) ? (out_ready ? FULL : FULL_PEND) :
                  load                 ? (two_word ? FULL_PEND : FULL) :
                  drain                ? EMPTY : state;
    end

    always_comb begin
        in_ready  = rst_n && ((state == EMPTY) || ((state == FULL) && out_ready));
        out_valid = state != EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst <= 32'd0;
            pend <= 32'd0;
            err  <= 1'b0;
        end else begin
            err <= accept && !legal;
            if (state == FULL_PEND) begin
                if (out_ready)
                    inst <= pend;
            end else if (load) begin
                inst <= word0;
                pend <= word1;
            end
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed and randomized checks of inst_encoder against a queue-based reference model.
module tb_inst_encoder;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [5:0]  I_fmt = 6'b100000;
    logic        pseudo_li = 0;
    logic [6:0]  opcode = 0;
    logic [2:0]  funct3 = 0;
    logic [6:0]  funct7 = 0;
    logic [4:0]  rd = 0, rs1 = 0, rs2 = 0;
    logic [31:0] imm32 = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] inst;
    logic        err;
    int          total = 0;
    int          bad = 0;

    inst_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .I_fmt(I_fmt), .pseudo_li(pseudo_li), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm32(imm32),
        .out_valid(out_valid), .out_ready(out_ready), .inst(inst), .err(err)
    );

    always #5 clk = ~clk;

    function automatic bit m_legal(input logic [5:0] f, input logic [2:0] f3, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        if ($countones(f) != 1) return 0;
        case (f)
            6'b100000: return 1;
            6'b010000: return (f3 == 3'd1 || f3 == 3'd5) ? (imm < 32) : (s >= -2048 && s <= 2047);
            6'b001000: return s >= -2048 && s <= 2047;
            6'b000100: return s >= -4096 && s <= 4095 && (s % 2 == 0);
            6'b000010: return (imm % 4096) == 0;
            default:   return s >= -(1 << 20) && s < (1 << 20) && (s % 2 == 0);
        endcase
    endfunction

    function automatic logic [31:0] m_enc(input logic [5:0] f, input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [4:0] d, input logic [4:0] a,
                                          input logic [4:0] b, input logic [31:0] m);
        case (f)
            6'b100000: return {f7, b, a, f3, d, op};
            6'b010000: return (f3 == 3'd1 || f3 == 3'd5) ? {f7, m[4:0], a, f3, d, op} : {m[11:0], a, f3, d, op};
            6'b001000: return {m[11:5], b, a, f3, m[4:0], op};
            6'b000100: return {m[12], m[10:5], b, a, f3, m[4:1], m[11], op};
            6'b000010: return {m[31:12], d, op};
            default:   return {m[20], m[10:1], m[11], m[19:12], d, op};
        endcase
    endfunction

    task automatic m_li(input logic [4:0] d, input logic [31:0] m, output int n, output logic [31:0] w0, output logic [31:0] w1);
        int s;
        logic [31:0] hi, lo;
        s  = $signed(m);
        hi = (m + 32'h800) >> 12;
        lo = m & 32'hFFF;
        w1 = (lo << 20) | (32'(d) << 15) | (32'(d) << 7) | 32'h13;
        if (s >= -2048 && s <= 2047) begin
            n  = 1;
            w0 = (lo << 20) | (32'(d) << 7) | 32'h13;
        end else begin
            w0 = (hi << 12) | (32'(d) << 7) | 32'h37;
            n  = (lo == 0) ? 1 : 2;
        end
    endtask

    task automatic set_req(input bit li, input logic [5:0] f, input logic [6:0] op, input logic [2:0] f3,
                           input logic [4:0] d, input logic [4:0] a, input logic [4:0] b, input logic [31:0] m);
        pseudo_li = li; I_fmt = f; opcode = op; funct3 = f3; funct7 = 7'h20;
        rd = d; rs1 = a; rs2 = b; imm32 = m;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; in_valid = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 0; in_valid = 1; out_ready = 1;
        #1;
        total++;
        if (out_valid !== 1'b0 || inst !== 32'd0 || err !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset: out_valid=%b inst=%h err=%b in_ready=%b, want 0 0 0 0", out_valid, inst, err, in_ready);
        end
        @(negedge clk);
        rst_n = 1; in_valid = 0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release: in_ready=%b want 1", in_ready); end
    endtask

    task automatic test_li_two_word();
        logic [31:0] exp_w [3];
        exp_w = '{32'h123462B7, 32'hFFF28293, 32'h0};
        @(negedge clk);
        set_req(1, 6'b100000, 0, 0, 5'd5, 0, 0, 32'h12345FFF);
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 0;
            #1;
            total++;
            if (out_valid !== (i < 2) || (i < 2 && inst !== exp_w[i])) begin
                bad++;
                $display("FAIL li_two_word[%0d]: out_valid=%b inst=%h want valid=%b inst=%h", i, out_valid, inst, i < 2, exp_w[i]);
            end
            if (i == 0) begin
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL li_two_word_ready: in_ready=%b want 0", in_ready); end
            end
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        set_req(0, 6'b000100, 7'b1100011, 3'b000, 0, 5'd1, 5'd2, 32'hFFFFFFFC);
        in_valid = 1; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        #1;
        total++;
        if (out_valid !== 1'b1 || inst !== 32'hFE208EE3 || err !== 1'b0) begin
            bad++;
            $display("FAIL branch: valid=%b inst=%h err=%b want 1 fe208ee3 0", out_valid, inst, err);
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        set_req(0, 6'b010000, 7'b0010011, 3'b000, 5'd3, 5'd4, 0, 32'h00000800);
        in_valid = 1; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        #1;
        total++;
        if (err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL illegal: err=%b valid=%b ready=%b want 1 0 1", err, out_valid, in_ready);
        end
        @(negedge clk);
        #1;
        total++;
        if (err !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL illegal_pulse: err=%b valid=%b want 0 0", err, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wa, wb;
        wa = m_enc(6'b100000, 7'b0110011, 3'b000, 7'h20, 5'd7, 5'd8, 5'd9, 0);
        wb = m_enc(6'b001000, 7'b0100011, 3'b010, 7'h20, 5'd0, 5'd10, 5'd11, 32'hFFFFF804);
        @(negedge clk);
        set_req(0, 6'b100000, 7'b0110011, 3'b000, 5'd7, 5'd8, 5'd9, 0);
        in_valid = 1; out_ready = 0;
        @(negedge clk);
        set_req(0, 6'b001000, 7'b0100011, 3'b010, 5'd0, 5'd10, 5'd11, 32'hFFFFF804);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (out_valid !== 1'b1 || inst !== wa || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall[%0d]: valid=%b inst=%h ready=%b want 1 %h 0", i, out_valid, inst, in_ready, wa);
            end
            @(negedge clk);
        end
        out_ready = 1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready: in_ready=%b want 1", in_ready); end
        @(negedge clk);
        in_valid = 0;
        #1;
        total++;
        if (out_valid !== 1'b1 || inst !== wb) begin
            bad++;
            $display("FAIL back_to_back: valid=%b inst=%h want 1 %h", out_valid, inst, wb);
        end
    endtask

    task automatic test_li_single();
        logic [31:0] imms [2];
        logic [31:0] exp_w [2];
        imms  = '{32'h00010000, 32'hFFFFFFFB};
        exp_w = '{32'h000100B7, 32'hFFB00093};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_req(1, 6'b000000, 0, 0, 5'd1, 0, 0, imms[i]);
            in_valid = 1; out_ready = 1;
            @(negedge clk);
            in_valid = 0;
            #1;
            total++;
            if (out_valid !== 1'b1 || inst !== exp_w[i]) begin
                bad++;
                $display("FAIL li_single[%0d]: valid=%b inst=%h want 1 %h", i, out_valid, inst, exp_w[i]);
            end
            @(negedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0 || err !== 1'b0) begin
                bad++;
                $display("FAIL li_single_end[%0d]: valid=%b err=%b want 0 0", i, out_valid, err);
            end
        end
    endtask

    task automatic test_reset_pend();
        @(negedge clk);
        set_req(1, 6'b000000, 0, 0, 5'd5, 0, 0, 32'h12345FFF);
        in_valid = 1; out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        #2;
        rst_n = 0;
        #1;
        total++;
        if (out_valid !== 1'b0 || inst !== 32'd0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_pend: valid=%b inst=%h ready=%b want 0 0 0", out_valid, inst, in_ready);
        end
        @(negedge clk);
        rst_n = 1; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_pend_after[%0d]: valid=%b inst=%h want valid 0", i, out_valid, inst);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] w0, w1;
        logic        exp_err, exp_ready;
        int          n;
        logic [5:0]  fmts [6];
        fmts = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001};
        do_reset();
        exp_err = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            pseudo_li = ($urandom_range(0, 3) == 0);
            I_fmt     = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fmts[$urandom_range(0, 5)];
            opcode    = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
            rd        = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            case ($urandom_range(0, 4))
                0: imm32 = $urandom;
                1: imm32 = 32'($signed(12'($urandom)));
                2: imm32 = 32'($signed(21'($urandom))) & ~32'h1;
                3: imm32 = $urandom & 32'hFFFFF000;
                default: imm32 = $urandom_range(0, 40);
            endcase
            #1;
            exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
            total++;
            if (out_valid !== (q.size() > 0) || (q.size() > 0 && inst !== q[0]) || err !== exp_err || in_ready !== exp_ready) begin
                bad++;
                $display("FAIL random[%0d]: valid=%b inst=%h err=%b ready=%b want %b %h %b %b",
                         c, out_valid, inst, err, in_ready, q.size() > 0, (q.size() > 0) ? q[0] : 32'h0, exp_err, exp_ready);
            end
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            exp_err = 0;
            if (in_valid && exp_ready) begin
                if (pseudo_li) begin
                    m_li(rd, imm32, n, w0, w1);
                    q.push_back(w0);
                    if (n == 2) q.push_back(w1);
                end else if (m_legal(I_fmt, funct3, imm32))
                    q.push_back(m_enc(I_fmt, opcode, funct3, funct7, rd, rs1, rs2, imm32));
                else
                    exp_err = 1;
            end
        end
        in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_li_two_word();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_li_single();
        test_reset_pend();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

RV32I instruction word encoder: the inverse of the core's immediate generator. A producer supplies a format, register fields, function fields and a 32-bit immediate. The block range-checks the immediate, scatters it into the RV32I instruction bit positions, and emits the 32-bit word on a valid/ready stream. It also expands the `li rd, imm32` pseudo-instruction into one or two real instructions. It sits between the self-test/boot program generator and the instruction memory write port.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block accepts request this cycle
- I_fmt  in  6  one-hot format: 100000 R, 010000 I, 001000 S, 000100 B, 000010 U, 000001 J
- pseudo_li  in  1  1 = expand `li rd, imm32`; I_fmt, opcode, funct3, funct7, rs1 and rs2 are ignored
- opcode  in  7  instruction bits [6:0]
- funct3  in  3  instruction bits [14:12]
- funct7  in  7  R format and shift-immediate bits [31:25]
- rd, rs1, rs2  in  5 each  register fields
- imm32  in  32  immediate, in the same form the immediate generator produces
- out_valid  out  1  inst holds a valid word
- out_ready  in  1  consumer takes inst this cycle
- inst  out  32  encoded instruction
- err  out  1  one-cycle pulse: previous accepted request was illegal and was dropped

## Operation
**Packing (f3 = funct3, op = opcode):**
- R: {funct7, rs2, rs1, f3, rd, op}
- I: {imm[11:0], rs1, f3, rd, op}
- I-shift (f3 = 001 or 101): {funct7, imm[4:0], rs1, f3, rd, op}
- S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
- B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
- U: {imm[31:12], rd, op}
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}

**Legality** (a violation drops the request and pulses err):
- I_fmt must be exactly one-hot.
- I and S: imm32 must equal the sign-extension of imm32[11:0].
- I-shift: imm32[31:5] must be 0.
- B: imm32 must be the sign-extension of its 13-bit value, and imm32[0] must be 0.
- J: imm32 must be the sign-extension of its 21-bit value, and imm32[0] must be 0.
- U: imm32[11:0] must be 0.
- R: imm32 is ignored.

**li expansion:**
- lo = imm32[11:0]; hi = (imm32 + 0x800)[31:12].
- If imm32 fits in 12 bits signed: emit one word, ADDI rd, x0, lo.
- Else if lo == 0: emit one word, LUI rd, hi.
- Otherwise: emit LUI rd, hi, then ADDI rd, rd, lo.
- Opcodes: LUI 0110111; ADDI 0010011 with f3 = 000.
- li requests never raise err.

**Round-trip property:** feeding inst back through the immediate generator with the same format returns imm32 for every legal request.

**State machine:**
- EMPTY: no word held.
- FULL: one word held.
- FULL_PEND: first li word held, second word stored internally.
- Transitions:
  - EMPTY → FULL on a legal accept.
  - FULL → EMPTY on drain with no accept.
  - FULL → FULL on drain plus simultaneous accept.
  - EMPTY or FULL → FULL_PEND on accepting a two-word li.
  - FULL_PEND → FULL on drain; the second word is loaded into inst.
- An illegal accept leaves the state as if no accept occurred, except that err is raised.
- in_ready = rst_n && (EMPTY || (FULL && out_ready)). in_ready is always 0 in FULL_PEND.

## Timing
- **Reset values:** out_valid 0, inst 0x00000000, err 0, state EMPTY. in_ready is 0 while rst_n is low.
- **Latency:** a word is on inst with out_valid = 1 in the cycle after the accepting edge.
- **Throughput:** one word per cycle when out_ready stays high. A two-word li occupies two output cycles and blocks new input for one cycle.
- **Stalls:** inst and out_valid are stable while out_valid && !out_ready.
- **err:** high for exactly the one cycle after an illegal accept. out_valid does not rise for that request. If a word was draining in the same cycle, out_valid falls.
- **Mid-operation reset:** reset asserted in any state, including FULL_PEND, clears everything immediately. A pending second li word is discarded and is not emitted after reset releases.

## Test plan
- li x5, 0x12345FFF, out_ready held 1 → inst 0x123462B7, then 0xFFF28293 on consecutive cycles; in_ready is 0 in the cycle 0x123462B7 is shown.
- B format, opcode 1100011, funct3 000, rs1 = 1, rs2 = 2, imm32 = 0xFFFFFFFC → inst 0xFE208EE3 one cycle after accept; err stays 0.
- I format, opcode 0010011, funct3 000, imm32 = 0x00000800 → err pulses one cycle, out_valid stays 0, in_ready stays 1.
- Back-to-back legal requests with out_ready held 0 for 3 cycles → inst is unchanged for 3 cycles and in_ready is 0; on release, the next request is accepted in the same cycle the first word drains.
- li x1, 0x00010000 → single word LUI, 0x000100B7. li x1, -5 → single word ADDI, 0xFFB00093.
- Two-word li accepted, rst_n pulled low in the FULL_PEND cycle → out_valid 0, inst 0 asynchronously; after release, no second word appears.
